// File: rtl/onehot_mux_pipe.sv
// Pipelined one-hot selector with valid/ready handshake; malformed selects are dropped and counted.
// Define ONEHOT_MUX_SKID_EN for the two-entry skid implementation with a registered iReady.
module onehot_mux_pipe #(
    parameter int NUM_CH     = 8,
    parameter int DATA_WIDTH = 32,
    parameter int ERR_W      = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH*DATA_WIDTH-1:0] iData,
    input  logic [NUM_CH-1:0]            select,
    input  logic                         iValid,
    output logic                         iReady,
    output logic [DATA_WIDTH-1:0]        oData,
    output logic                         oValid,
    input  logic                         oReady,
    input  logic                         errClr,
    output logic                         oErr,
    output logic [ERR_W-1:0]             errCount
);

    localparam logic [NUM_CH-1:0] SEL_ONE = {{(NUM_CH-1){1'b0}}, 1'b1};
    localparam logic [ERR_W-1:0]  ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

    logic                  sel_ok;
    logic [DATA_WIDTH-1:0] sel_word;
    logic                  accept;
    logic                  good_acc;
    logic                  bad_acc;

    // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing.
    assign sel_ok = (select != '0) && ((select & (select - SEL_ONE)) == '0);

    always_comb begin
        sel_word = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (select[k]) begin
                sel_word = sel_word | iData[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign accept   = iValid & iReady;
    assign good_acc = accept & sel_ok;
    assign bad_acc  = accept & ~sel_ok;

    logic             err_q, err_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_d     = bad_acc;
        err_cnt_d = err_cnt_q;
        if (errClr) begin
            err_cnt_d = '0;
        end else if (bad_acc && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign oErr     = err_q;
    assign errCount = err_cnt_q;

`ifdef ONEHOT_MUX_SKID_EN
    // state    | meaning
    // ST_EMPTY | nothing held, oValid=0
    // ST_BUSY  | output register loaded, skid slot empty
    // ST_FULL  | output register and skid slot loaded, iReady=0
    typedef enum logic [1:0] {ST_EMPTY, ST_BUSY, ST_FULL} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
    logic                  ready_q, ready_d;

    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        skid_data_d = skid_data_q;
        case (state_q)
            ST_EMPTY: begin
                if (good_acc) begin
                    state_d    = ST_BUSY;
                    out_data_d = sel_word;
                end
            end
            ST_BUSY: begin
                if (good_acc && !oReady) begin
                    state_d     = ST_FULL;
                    skid_data_d = sel_word;
                end else if (good_acc) begin
                    out_data_d = sel_word;
                end else if (oReady) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (oReady) begin
                    state_d    = ST_BUSY;
                    out_data_d = skid_data_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Registered from next state so oReady never reaches iReady combinationally.
        ready_d = (state_d != ST_FULL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            out_data_q  <= '0;
            skid_data_q <= '0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            skid_data_q <= skid_data_d;
            ready_q     <= ready_d;
        end
    end

    assign iReady = ready_q;
    assign oValid = (state_q != ST_EMPTY);
    assign oData  = out_data_q;
`else
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (good_acc) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_word;
        end else if (oReady) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign iReady = ~out_valid_q | oReady;
    assign oValid = out_valid_q;
    assign oData  = out_data_q;
`endif

endmodule

// File: tb/tb_onehot_mux_pipe.sv
// Directed bench for onehot_mux_pipe (NUM_CH=8, DATA_WIDTH=32, ERR_W=2); expectations cover both builds.
module tb_onehot_mux_pipe;

    localparam int NUM_CH     = 8;
    localparam int DATA_WIDTH = 32;
    localparam int ERR_W      = 2;

    logic                         clk;
    logic                         rst;
    logic [NUM_CH*DATA_WIDTH-1:0] iData;
    logic [NUM_CH-1:0]            select;
    logic                         iValid;
    logic                         iReady;
    logic [DATA_WIDTH-1:0]        oData;
    logic                         oValid;
    logic                         oReady;
    logic                         errClr;
    logic                         oErr;
    logic [ERR_W-1:0]             errCount;

    int n_checks = 0;
    int n_errors = 0;

    onehot_mux_pipe #(
        .NUM_CH    (NUM_CH),
        .DATA_WIDTH(DATA_WIDTH),
        .ERR_W     (ERR_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .iData   (iData),
        .select  (select),
        .iValid  (iValid),
        .iReady  (iReady),
        .oData   (oData),
        .oValid  (oValid),
        .oReady  (oReady),
        .errClr  (errClr),
        .oErr    (oErr),
        .errCount(errCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_channels(input logic [31:0] base);
        for (int k = 0; k < NUM_CH; k++) begin
            iData[k*DATA_WIDTH +: DATA_WIDTH] = base + 32'(k);
        end
    endtask

    task automatic sel_ch(input int k);
        select = '0;
        select[k] = 1'b1;
    endtask

    initial begin
        rst    = 1'b1;
        iData  = '0;
        select = '0;
        iValid = 1'b0;
        oReady = 1'b1;
        errClr = 1'b0;
        load_channels(32'h1000_0000);
        step();
        step();
        check("rst_ovalid",   32'(oValid),   32'd0);
        check("rst_odata",    oData,         32'd0);
        check("rst_oerr",     32'(oErr),     32'd0);
        check("rst_errcount", 32'(errCount), 32'd0);
        check("rst_iready",   32'(iReady),   32'd1);
        rst = 1'b0;

        // Streaming: one beat per cycle, latency 1
        for (int i = 0; i < NUM_CH; i++) begin
            sel_ch(i);
            iValid = 1'b1;
            step();
            check("stream_ovalid", 32'(oValid), 32'd1);
            check("stream_odata",  oData,       32'h1000_0000 + 32'(i));
            check("stream_iready", 32'(iReady), 32'd1);
        end
        iValid = 1'b0;
        step();
        check("drain_ovalid", 32'(oValid), 32'd0);

        // Malformed selects are dropped; only the valid one is forwarded
        iData[2*DATA_WIDTH +: DATA_WIDTH] = 32'hCAFE_0002;
        select = 8'h00;
        iValid = 1'b1;
        step();
        check("bad0_oerr",   32'(oErr),     32'd1);
        check("bad0_ovalid", 32'(oValid),   32'd0);
        check("bad0_cnt",    32'(errCount), 32'd1);
        select = 8'h03;
        step();
        check("bad3_oerr",   32'(oErr),     32'd1);
        check("bad3_ovalid", 32'(oValid),   32'd0);
        check("bad3_cnt",    32'(errCount), 32'd2);
        select = 8'h04;
        step();
        check("good4_oerr",   32'(oErr),     32'd0);
        check("good4_ovalid", 32'(oValid),   32'd1);
        check("good4_odata",  oData,         32'hCAFE_0002);
        check("good4_cnt",    32'(errCount), 32'd2);
        iValid = 1'b0;
        step();
        check("good4_once", 32'(oValid), 32'd0);
        check("idle_oerr",  32'(oErr),   32'd0);

        // Backpressure
        load_channels(32'h1000_0000);
        oReady = 1'b0;
        iValid = 1'b1;
        sel_ch(0);
        step();
        check("bp1_ovalid", 32'(oValid), 32'd1);
        check("bp1_odata",  oData,       32'h1000_0000);
`ifdef ONEHOT_MUX_SKID_EN
        check("bp1_iready", 32'(iReady), 32'd1);
`else
        check("bp1_iready", 32'(iReady), 32'd0);
`endif
        sel_ch(1);
        step();
        check("bp2_odata",  oData,       32'h1000_0000);
        check("bp2_iready", 32'(iReady), 32'd0);
        sel_ch(2);
        step();
        check("bp3_odata",  oData,       32'h1000_0000);
        check("bp3_ovalid", 32'(oValid), 32'd1);
        check("bp3_iready", 32'(iReady), 32'd0);
        iValid = 1'b0;
        oReady = 1'b1;
        step();
`ifdef ONEHOT_MUX_SKID_EN
        check("bp_drain_b_ovalid", 32'(oValid), 32'd1);
        check("bp_drain_b_odata",  oData,       32'h1000_0001);
        step();
`endif
        check("bp_empty_ovalid", 32'(oValid), 32'd0);
        check("bp_empty_iready", 32'(iReady), 32'd1);

        // Saturation at 2^ERR_W-1 and clear priority
        errClr = 1'b1;
        step();
        errClr = 1'b0;
        check("clr_cnt", 32'(errCount), 32'd0);
        select = 8'h00;
        iValid = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            check("sat_oerr", 32'(oErr),     32'd1);
            check("sat_cnt",  32'(errCount), (i < 3) ? 32'(i) : 32'd3);
        end
        errClr = 1'b1;
        step();
        check("clrwin_cnt",  32'(errCount), 32'd0);
        check("clrwin_oerr", 32'(oErr),     32'd1);
        errClr = 1'b0;
        iValid = 1'b0;
        step();
        check("post_clr_oerr", 32'(oErr),     32'd0);
        check("post_clr_cnt",  32'(errCount), 32'd0);

        // Async reset while holding beats
        select = 8'h00;
        iValid = 1'b1;
        step();
        check("pre_rst_cnt", 32'(errCount), 32'd1);
        oReady = 1'b0;
        sel_ch(3);
        step();
        sel_ch(4);
        step();
        check("pre_rst_iready", 32'(iReady), 32'd0);
        check("pre_rst_odata",  oData,       32'h1000_0003);
        iValid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst_ovalid",   32'(oValid),   32'd0);
        check("arst_iready",   32'(iReady),   32'd1);
        check("arst_errcount", 32'(errCount), 32'd0);
        check("arst_odata",    oData,         32'd0);
        #2;
        rst    = 1'b0;
        oReady = 1'b1;
        sel_ch(5);
        iValid = 1'b1;
        step();
        check("post_rst_ovalid", 32'(oValid), 32'd1);
        check("post_rst_odata",  oData,       32'h1000_0005);
        iValid = 1'b0;
        step();
        check("post_rst_drain", 32'(oValid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
